// File: rtl/axis_byte_reverse.sv
`default_nettype none
// ============================================================================
// Module      : axis_byte_reverse
// Description : AXI-Stream byte-lane reversal stage with a per-packet swap
//               mode and a two-entry skid buffer. Both output valid and
//               input ready come straight from flops.
//
//   Ports
//     core_clk    in   clock, rising edge
//     core_rst_n  in   asynchronous active-low reset
//     swap_en     in   1 = reverse byte lanes, sampled on each packet's first beat
//     in_tdata    in   input data, byte 0 = bits [7:0]
//     in_tkeep    in   input byte enables
//     in_tvalid   in   input beat valid
//     in_tready   out  input ready (registered)
//     in_tlast    in   last beat of input packet
//     out_tdata   out  output data
//     out_tkeep   out  output byte enables
//     out_tvalid  out  output beat valid (registered)
//     out_tready  in   downstream ready
//     out_tlast   out  last beat of output packet
//     keep_err    out  one-cycle pulse after a malformed-tkeep beat is accepted
//
// Revision    : 1.0 - initial release
// ============================================================================
module axis_byte_reverse #(
    parameter int DATA_BYTES = 8,
    parameter bit KEEP_CHECK = 1'b1
) (
    input  logic                      core_clk,
    input  logic                      core_rst_n,
    input  logic                      swap_en,
    input  logic [8*DATA_BYTES-1:0]   in_tdata,
    input  logic [DATA_BYTES-1:0]     in_tkeep,
    input  logic                      in_tvalid,
    output logic                      in_tready,
    input  logic                      in_tlast,
    output logic [8*DATA_BYTES-1:0]   out_tdata,
    output logic [DATA_BYTES-1:0]     out_tkeep,
    output logic                      out_tvalid,
    input  logic                      out_tready,
    output logic                      out_tlast,
    output logic                      keep_err
);

    localparam int                  c_DATA_W   = 8 * DATA_BYTES;
    localparam logic [DATA_BYTES-1:0] c_KEEP_ALL = {DATA_BYTES{1'b1}};
    localparam logic [DATA_BYTES:0]   c_ONE_EXT  = {{DATA_BYTES{1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [1:0]            count_q,      count_d;
    logic [c_DATA_W-1:0]   main_data_q,  main_data_d;
    logic [DATA_BYTES-1:0] main_keep_q,  main_keep_d;
    logic                  main_last_q,  main_last_d;
    logic [c_DATA_W-1:0]   skid_data_q,  skid_data_d;
    logic [DATA_BYTES-1:0] skid_keep_q,  skid_keep_d;
    logic                  skid_last_q,  skid_last_d;
    logic                  sop_q,        sop_d;
    logic                  mode_q,       mode_d;
    logic                  in_tready_q,  in_tready_d;
    logic                  out_tvalid_q, out_tvalid_d;
    logic                  keep_err_q,   keep_err_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                  w_accept;
    logic                  w_pop;
    logic                  w_swap;
    logic                  w_keep_bad;
    logic [c_DATA_W-1:0]   w_rev_data;
    logic [DATA_BYTES-1:0] w_rev_keep;
    logic [c_DATA_W-1:0]   w_xf_data;
    logic [DATA_BYTES-1:0] w_xf_keep;

    assign w_accept = in_tvalid & in_tready_q;
    assign w_pop    = out_tvalid_q & out_tready;

    // The first beat of a packet uses the live swap_en; later beats use the
    // value captured on that first beat, so mid-packet toggles are ignored.
    assign w_swap = sop_q ? swap_en : mode_q;

    // Lane mirror: output lane i takes input lane DATA_BYTES-1-i.
    // With a single lane this degenerates to a straight wire.
    for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_lane
        assign w_rev_data[8*gi +: 8] = in_tdata[8*(DATA_BYTES-1-gi) +: 8];
        assign w_rev_keep[gi]        = in_tkeep[DATA_BYTES-1-gi];
    end

    // Beats are transformed before storage so both buffer entries always
    // hold output-ready data.
    assign w_xf_data = w_swap ? w_rev_data : in_tdata;
    assign w_xf_keep = w_swap ? w_rev_keep : in_tkeep;

    // ------------------------------------------------------------------
    // tkeep sanity check (on the pre-swap keep)
    // ------------------------------------------------------------------
    if (KEEP_CHECK) begin : g_keep_chk
        logic [DATA_BYTES:0] w_keep_inc;
        logic                w_keep_contig;

        // A run of ones starting at bit 0 becomes a single higher one after
        // +1, so ANDing with the original leaves nothing behind.
        assign w_keep_inc    = {1'b0, in_tkeep} + c_ONE_EXT;
        assign w_keep_contig = ((in_tkeep & w_keep_inc[DATA_BYTES-1:0]) == '0);

        assign w_keep_bad = in_tlast ? ((in_tkeep == '0) || !w_keep_contig)
                                     : (in_tkeep != c_KEEP_ALL);
    end else begin : g_keep_off
        assign w_keep_bad = 1'b0;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        count_d     = count_q;
        main_data_d = main_data_q;
        main_keep_d = main_keep_q;
        main_last_d = main_last_q;
        skid_data_d = skid_data_q;
        skid_keep_d = skid_keep_q;
        skid_last_d = skid_last_q;
        sop_d       = sop_q;
        mode_d      = mode_q;
        keep_err_d  = 1'b0;

        case (count_q)
            2'd0: begin
                if (w_accept) begin
                    main_data_d = w_xf_data;
                    main_keep_d = w_xf_keep;
                    main_last_d = in_tlast;
                    count_d     = 2'd1;
                end
            end
            2'd1: begin
                if (w_accept && w_pop) begin
                    // Main drains and refills in the same cycle.
                    main_data_d = w_xf_data;
                    main_keep_d = w_xf_keep;
                    main_last_d = in_tlast;
                end else if (w_accept) begin
                    skid_data_d = w_xf_data;
                    skid_keep_d = w_xf_keep;
                    skid_last_d = in_tlast;
                    count_d     = 2'd2;
                end else if (w_pop) begin
                    count_d     = 2'd0;
                end
            end
            default: begin
                // Full: in_tready is low, so only a pop can happen here.
                if (w_pop) begin
                    main_data_d = skid_data_q;
                    main_keep_d = skid_keep_q;
                    main_last_d = skid_last_q;
                    count_d     = 2'd1;
                end
            end
        endcase

        if (w_accept) begin
            if (sop_q) begin
                mode_d = swap_en;
            end
            sop_d      = in_tlast;
            keep_err_d = w_keep_bad;
        end

        in_tready_d  = (count_d != 2'd2);
        out_tvalid_d = (count_d != 2'd0);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            count_q      <= 2'd0;
            main_data_q  <= '0;
            main_keep_q  <= '0;
            main_last_q  <= 1'b0;
            skid_data_q  <= '0;
            skid_keep_q  <= '0;
            skid_last_q  <= 1'b0;
            sop_q        <= 1'b1;
            mode_q       <= 1'b0;
            in_tready_q  <= 1'b0;
            out_tvalid_q <= 1'b0;
            keep_err_q   <= 1'b0;
        end else begin
            count_q      <= count_d;
            main_data_q  <= main_data_d;
            main_keep_q  <= main_keep_d;
            main_last_q  <= main_last_d;
            skid_data_q  <= skid_data_d;
            skid_keep_q  <= skid_keep_d;
            skid_last_q  <= skid_last_d;
            sop_q        <= sop_d;
            mode_q       <= mode_d;
            in_tready_q  <= in_tready_d;
            out_tvalid_q <= out_tvalid_d;
            keep_err_q   <= keep_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_tready  = in_tready_q;
    assign out_tvalid = out_tvalid_q;
    assign out_tdata  = main_data_q;
    assign out_tkeep  = main_keep_q;
    assign out_tlast  = main_last_q;
    assign keep_err   = keep_err_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_byte_reverse.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_byte_reverse
// Description : Self-checking bench for axis_byte_reverse (DATA_BYTES=8,
//               KEEP_CHECK=1): table of single-beat packets, hand-written
//               multi-beat sequences, a randomized stream checked against a
//               packet-level reference model, and a mid-packet reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_byte_reverse;

    localparam int NB = 8;

    logic          core_clk   = 1'b0;
    logic          core_rst_n = 1'b1;
    logic          swap_en    = 1'b0;
    logic [63:0]   in_tdata   = '0;
    logic [7:0]    in_tkeep   = '0;
    logic          in_tvalid  = 1'b0;
    logic          in_tready;
    logic          in_tlast   = 1'b0;
    logic [63:0]   out_tdata;
    logic [7:0]    out_tkeep;
    logic          out_tvalid;
    logic          out_tready = 1'b1;
    logic          out_tlast;
    logic          keep_err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 core_clk = ~core_clk;

    axis_byte_reverse #(
        .DATA_BYTES (NB),
        .KEEP_CHECK (1'b1)
    ) dut (
        .core_clk   (core_clk),
        .core_rst_n (core_rst_n),
        .swap_en    (swap_en),
        .in_tdata   (in_tdata),
        .in_tkeep   (in_tkeep),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .in_tlast   (in_tlast),
        .out_tdata  (out_tdata),
        .out_tkeep  (out_tkeep),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .out_tlast  (out_tlast),
        .keep_err   (keep_err)
    );

    // ------------------------------------------------------------------
    // Helpers and reference model
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_rev_data(input logic [63:0] d);
        byte unsigned b [NB];
        logic [63:0]  r;
        for (int i = 0; i < NB; i++) b[i] = d[8*i +: 8];
        r = '0;
        for (int i = 0; i < NB; i++) r = (r << 8) | 64'(b[i]);
        return r;
    endfunction

    function automatic logic [7:0] ref_rev_keep(input logic [7:0] k);
        logic [7:0] r = '0;
        for (int i = 0; i < NB; i++) r[i] = k[NB-1-i];
        return r;
    endfunction

    function automatic bit ref_keep_bad(input logic [7:0] k, input bit last);
        bit seen_zero = 1'b0;
        if (!last) return (k != 8'hFF);
        if (k == 8'h00) return 1'b1;
        for (int i = 0; i < NB; i++) begin
            if (!k[i]) seen_zero = 1'b1;
            else if (seen_zero) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [7:0] pick_keep(input bit last);
        logic [7:0] t;
        if (!last) return ($urandom_range(0, 99) < 85) ? 8'hFF : 8'($urandom);
        case ($urandom_range(0, 3))
            0:       t = 8'hFF;
            1:       t = 8'($urandom);
            default: begin t = 8'hFF; t = t >> $urandom_range(0, 7); end
        endcase
        return t;
    endfunction

    // Drive one beat (called at a negedge with out_tready=1), check it on the
    // following negedge, then check it drained and keep_err fell.
    task automatic send_check(input string name, input logic [63:0] d, input logic [7:0] k,
                              input logic l, input logic s, input logic [63:0] ed,
                              input logic [7:0] ek, input logic ee);
        in_tdata  = d;
        in_tkeep  = k;
        in_tlast  = l;
        swap_en   = s;
        in_tvalid = 1'b1;
        chk({name, ".in_tready"}, 64'(in_tready), 64'(1));
        @(posedge core_clk);
        @(negedge core_clk);
        in_tvalid = 1'b0;
        chk({name, ".tvalid"},   64'(out_tvalid), 64'(1));
        chk({name, ".tdata"},    out_tdata, ed);
        chk({name, ".tkeep"},    64'(out_tkeep), 64'(ek));
        chk({name, ".tlast"},    64'(out_tlast), 64'(l));
        chk({name, ".keep_err"}, 64'(keep_err), 64'(ee));
        @(posedge core_clk);
        @(negedge core_clk);
        chk({name, ".err_pulse"}, 64'(keep_err), 64'(0));
        chk({name, ".drained"},   64'(out_tvalid), 64'(0));
    endtask

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        s;
        logic [63:0] ed;
        logic [7:0]  ek;
        logic        ee;
    } vec_t;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    vec_t tbl [8];

    // Global watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t q [$];
        beat_t b, e;
        bit    pkt_open, pkt_swap, err_next, do_swap;
        int    accepted, cyc;

        // Single-beat packets (tlast=1) with hand-derived expectations
        tbl[0] = '{64'h0807060504030201, 8'hFF, 1'b1, 64'h0102030405060708, 8'hFF, 1'b0};
        tbl[1] = '{64'h0000000000CCBBAA, 8'h07, 1'b1, 64'hAABBCC0000000000, 8'hE0, 1'b0};
        tbl[2] = '{64'h0000000000CCBBAA, 8'h07, 1'b0, 64'h0000000000CCBBAA, 8'h07, 1'b0};
        tbl[3] = '{64'h1122334455667788, 8'h05, 1'b0, 64'h1122334455667788, 8'h05, 1'b1};
        tbl[4] = '{64'h1122334455667788, 8'h00, 1'b1, 64'h8877665544332211, 8'h00, 1'b1};
        tbl[5] = '{64'hDEADBEEFCAFEF00D, 8'h7F, 1'b1, 64'h0DF0FECAEFBEADDE, 8'hFE, 1'b0};
        tbl[6] = '{64'h0123456789ABCDEF, 8'h0F, 1'b1, 64'hEFCDAB8967452301, 8'hF0, 1'b0};
        tbl[7] = '{64'h00000000000000A5, 8'h01, 1'b0, 64'h00000000000000A5, 8'h01, 1'b0};

        // ---------------- reset state ----------------
        #1 core_rst_n = 1'b0;
        @(negedge core_clk);
        @(negedge core_clk);
        chk("rst.out_tvalid", 64'(out_tvalid), 64'(0));
        chk("rst.out_tdata",  out_tdata, 64'(0));
        chk("rst.out_tkeep",  64'(out_tkeep), 64'(0));
        chk("rst.out_tlast",  64'(out_tlast), 64'(0));
        chk("rst.in_tready",  64'(in_tready), 64'(0));
        chk("rst.keep_err",   64'(keep_err), 64'(0));
        core_rst_n = 1'b1;
        @(posedge core_clk);
        @(negedge core_clk);
        chk("rst_rel.in_tready", 64'(in_tready), 64'(1));

        // ---------------- table of single-beat packets ----------------
        for (int i = 0; i < 8; i++) begin
            send_check($sformatf("tbl%0d", i), tbl[i].d, tbl[i].k, 1'b1, tbl[i].s,
                       tbl[i].ed, tbl[i].ek, tbl[i].ee);
        end

        // ---------------- mode latched on first beat ----------------
        send_check("mode.b1", 64'h1111111122222222, 8'hFF, 1'b0, 1'b0,
                   64'h1111111122222222, 8'hFF, 1'b0);
        send_check("mode.b2", 64'h0807060504030201, 8'hFF, 1'b0, 1'b1,
                   64'h0807060504030201, 8'hFF, 1'b0);
        send_check("mode.b3", 64'h00000000A1B2C3D4, 8'h0F, 1'b1, 1'b1,
                   64'h00000000A1B2C3D4, 8'h0F, 1'b0);
        send_check("mode.next", 64'h00000000A1B2C3D4, 8'h0F, 1'b1, 1'b1,
                   64'hD4C3B2A100000000, 8'hF0, 1'b0);

        // ---------------- keep errors inside a packet ----------------
        send_check("kerr.mid", 64'h00FFEEDDCCBBAA99, 8'h7F, 1'b0, 1'b0,
                   64'h00FFEEDDCCBBAA99, 8'h7F, 1'b1);
        send_check("kerr.last", 64'h0000000000330011, 8'h05, 1'b1, 1'b1,
                   64'h0000000000330011, 8'h05, 1'b1);

        // ---------------- randomized stream vs reference model ----------------
        pkt_open = 1'b0;
        pkt_swap = 1'b0;
        err_next = 1'b0;
        accepted = 0;
        cyc      = 0;
        while ((accepted < 100 || q.size() != 0) && cyc < 3000) begin
            chk("rnd.keep_err",   64'(keep_err),   64'(err_next));
            chk("rnd.in_tready",  64'(in_tready),  64'(q.size() < 2));
            chk("rnd.out_tvalid", 64'(out_tvalid), 64'(q.size() != 0));

            out_tready = (accepted < 100) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (accepted < 100) begin
                in_tvalid = 1'b1;
                in_tdata  = {$urandom, $urandom};
                in_tlast  = ($urandom_range(0, 3) == 0);
                in_tkeep  = pick_keep(in_tlast);
                swap_en   = 1'($urandom_range(0, 1));
            end else begin
                in_tvalid = 1'b0;
            end

            if (out_tvalid && out_tready && q.size() != 0) begin
                e = q.pop_front();
                chk("rnd.tdata", out_tdata, e.d);
                chk("rnd.tkeep", 64'(out_tkeep), 64'(e.k));
                chk("rnd.tlast", 64'(out_tlast), 64'(e.l));
            end

            err_next = 1'b0;
            if (in_tvalid && in_tready) begin
                if (!pkt_open) begin
                    pkt_swap = swap_en;
                    pkt_open = 1'b1;
                end
                do_swap  = pkt_swap;
                b.d      = do_swap ? ref_rev_data(in_tdata) : in_tdata;
                b.k      = do_swap ? ref_rev_keep(in_tkeep) : in_tkeep;
                b.l      = in_tlast;
                q.push_back(b);
                err_next = ref_keep_bad(in_tkeep, in_tlast);
                if (in_tlast) pkt_open = 1'b0;
                accepted++;
            end

            @(posedge core_clk);
            @(negedge core_clk);
            cyc++;
        end
        in_tvalid = 1'b0;
        if (cyc >= 3000) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rnd.timeout: accepted %0d of 100, %0d beats still queued", accepted, q.size());
        end

        // ---------------- reset while full, mid-packet ----------------
        out_tready = 1'b0;
        swap_en    = 1'b0;
        in_tkeep   = 8'hFF;
        in_tlast   = 1'b0;
        in_tvalid  = 1'b1;
        in_tdata   = 64'hAAAAAAAAAAAAAAAA;
        @(posedge core_clk);
        @(negedge core_clk);
        in_tdata   = 64'hBBBBBBBBBBBBBBBB;
        @(posedge core_clk);
        @(negedge core_clk);
        in_tvalid  = 1'b0;
        chk("full.in_tready",  64'(in_tready),  64'(0));
        chk("full.out_tvalid", 64'(out_tvalid), 64'(1));
        #2 core_rst_n = 1'b0;
        #1;
        chk("arst.out_tvalid", 64'(out_tvalid), 64'(0));
        chk("arst.in_tready",  64'(in_tready),  64'(0));
        @(negedge core_clk);
        core_rst_n = 1'b1;
        @(posedge core_clk);
        @(negedge core_clk);
        chk("arst_rel.in_tready",  64'(in_tready),  64'(1));
        chk("arst_rel.out_tvalid", 64'(out_tvalid), 64'(0));
        chk("arst_rel.out_tdata",  out_tdata, 64'(0));
        out_tready = 1'b1;
        send_check("arst.sop", 64'h0807060504030201, 8'hFF, 1'b1, 1'b1,
                   64'h0102030405060708, 8'hFF, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
